piso_frame_shifter: RTL

//   Parametrised parallel-in/serial-out shift register, the next generation of the
//   8-bit '165-style PISO. It adds configurable width and bit order, and a

---
 rtl/piso_frame_shifter_pkg.sv | 7 +
 rtl/piso_frame_shifter_if.sv | 17 +
 rtl/piso_frame_shifter.sv | 70 +++++++
 3 files changed

// File: rtl/piso_frame_shifter_pkg.sv
// piso_frame_shifter_pkg: shared state type and counter-width helper for the PISO frame shifter
package piso_pkg;
  typedef enum logic {IDLE, SHIFT} piso_state_t;
  function automatic int cnt_w(int w);
    return $clog2(w + 1);
  endfunction
endpackage

// File: rtl/piso_frame_shifter_if.sv
// piso_frame_shifter_if: control, data and status bundle of the PISO frame shifter
interface piso_frame_shifter_if #(parameter int WIDTH = 8);
  import piso_pkg::*;
  localparam int CW = cnt_w(WIDTH);
  logic load;
  logic start;
  logic inhibit;
  logic ds;
  logic [WIDTH-1:0] p;
  logic q;
  logic qb;
  logic busy;
  logic done;
  logic [CW-1:0] count;
  modport master(output load, start, inhibit, ds, p, input q, qb, busy, done, count);
  modport slave(input load, start, inhibit, ds, p, output q, qb, busy, done, count);
endinterface

// File: rtl/piso_frame_shifter.sv
// piso_frame_shifter: parametrised PISO shift register with framed transmit, busy/done status and bit counter
module piso_frame_shifter
  import piso_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic clk,
  input logic rst,
  piso_frame_shifter_if.slave bus
);
  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);
  piso_state_t state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n, shifted;
  logic [CW-1:0] cnt, cnt_n;
  logic done, done_n;
  generate
    if (MSB_FIRST) begin : g_msb
      assign shifted = {shreg[WIDTH-2:0], bus.ds};
      assign bus.q = shreg[WIDTH-1];
    end else begin : g_lsb
      assign shifted = {bus.ds, shreg[WIDTH-1:1]};
      assign bus.q = shreg[0];
    end
  endgenerate
  assign bus.qb = ~bus.q;
  assign bus.busy = (state == SHIFT);
  assign bus.done = done;
  assign bus.count = cnt;
  // next-state: load aborts, start only from idle, inhibit freezes, otherwise shift and count down a frame
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n = cnt;
    done_n = 1'b0;
    if (bus.load) begin
      shreg_n = bus.p;
      state_n = IDLE;
      cnt_n = '0;
    end else if (bus.start && state == IDLE) begin
      shreg_n = bus.p;
      state_n = SHIFT;
      cnt_n = FULL;
    end else if (!bus.inhibit) begin
      shreg_n = shifted;
      if (state == SHIFT) begin
        cnt_n = cnt - 1'b1;
        if (cnt == CW'(1)) begin
          state_n = IDLE;
          done_n = 1'b1;
        end
      end
    end
  end
  // state and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      cnt <= cnt_n;
      done <= done_n;
    end
  end
endmodule
